sd_cmd_arbiter: RTL and testbench
=================================

Name: sd_cmd_arbiter

Overview:
- Owns the single CMD-line issuer and shares it between two requesters:
  - software commands, from Command register writes;
  - Auto CMD12, requested by the DAT path when a multi-block transfer finishes.
- Sequences each command from issue through response completion.
- Drives Command Inhibit (CMD), and reports completion and errors per requester.
- Sits between the register file / DAT wrapper and the CMD-line serializer.

Parameters:
- TimeoutCycles, 64: number of SD clock rising-edge enables to wait for cmd_done_i before declaring a timeout. Used only with the optional feature.
- Cmd12Index, 12: command index issued for Auto CMD12.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sd_clk_en_p_i  in  1  SD clock rising-edge enable
- soft_rst_i  in  1  software reset for CMD; synchronous flush
- sw_cmd_valid_i  in  1  one-cycle pulse; Command register written
- sw_cmd_index_i  in  6  software command index
- sw_cmd_arg_i  in  32  software command argument
- sw_rsp_type_i  in  2  response type (00 none, 01 R136, 10 R48, 11 R48b)
- auto_cmd12_req_i  in  1  one-cycle pulse from the DAT path
- cmd_start_o  out  1  one-cycle start pulse to the serializer
- cmd_index_o  out  6  index presented to the serializer
- cmd_arg_o  out  32  argument presented to the serializer
- cmd_rsp_type_o  out  2  response type presented to the serializer
- cmd_done_i  in  1  pulse; serializer finished, response received
- cmd_err_i  in  1  qualified by cmd_done_i; CRC, end-bit or index error
- cmd_inhibit_o  out  1  CMD line busy
- sw_cmd_complete_o  out  1  pulse; software command done
- sw_cmd_err_o  out  1  pulse; software command error
- sw_cmd_dropped_o  out  1  pulse; software command rejected
- auto_cmd12_active_o  out  1  Auto CMD12 pending or in flight
- auto_cmd12_done_o  out  1  pulse; Auto CMD12 done
- auto_cmd12_err_o  out  1  pulse; Auto CMD12 error
- cmd_timeout_o  out  1  pulse; timeout (optional feature only, else tied 0)

Behaviour:
- Reset values: all outputs 0; cmd_index_o, cmd_arg_o, cmd_rsp_type_o = 0; state IDLE; both pending flags clear.
- Pending flags:
  - auto_pend is set by auto_cmd12_req_i in any state.
  - sw_pend is set by sw_cmd_valid_i only while in IDLE with no pending command. sw_cmd_index_i, sw_cmd_arg_i and sw_rsp_type_i are captured in the same cycle.
  - A sw_cmd_valid_i pulse in any other condition is discarded and produces a 1-cycle sw_cmd_dropped_o; the captured fields are unchanged.
- Output qualifiers:
  - cmd_inhibit_o = (state != IDLE) | sw_pend | auto_pend.
  - auto_cmd12_active_o = auto_pend | (state in ISSUE_AUTO or WAIT_AUTO).
- States:
  - IDLE:
    - If auto_pend: load index Cmd12Index, arg 0, type 11; clear auto_pend; go to ISSUE_AUTO.
    - Else if sw_pend: load the captured fields; clear sw_pend; go to ISSUE_SW.
    - Auto CMD12 wins a simultaneous request, including pulses arriving in the same cycle.
  - ISSUE_SW / ISSUE_AUTO: wait for sd_clk_en_p_i. In that cycle, pulse cmd_start_o for exactly 1 cycle and go to WAIT_SW / WAIT_AUTO.
  - WAIT_SW: on cmd_done_i, pulse sw_cmd_complete_o; also pulse sw_cmd_err_o if cmd_err_i. Go to IDLE.
  - WAIT_AUTO: same, using auto_cmd12_done_o and auto_cmd12_err_o.
- Timing:
  - cmd_index_o, cmd_arg_o and cmd_rsp_type_o are registered. They are stable from ISSUE entry until return to IDLE.
  - Latency from request pulse to cmd_start_o: minimum 2 cycles (capture, IDLE→ISSUE), then 0 or more cycles waiting for sd_clk_en_p_i.
- Edge cases:
  - An auto_cmd12_req_i arriving during WAIT_SW is queued. It issues immediately after the software command completes.
  - cmd_done_i outside the WAIT states is ignored.
- soft_rst_i: synchronous; same effect as reset (state IDLE, pending flags cleared, pulses suppressed) but does not clear the captured fields. It takes priority over all other events in that cycle.
- rst_ni asserted mid-command: immediate return to reset values. No completion pulses are produced.

Optional Feature:
- Macro SDHCI_CMD_TIMEOUT_EN.
- Defined:
  - In WAIT_SW and WAIT_AUTO, a counter increments on sd_clk_en_p_i.
  - When it reaches TimeoutCycles without cmd_done_i: pulse cmd_timeout_o and the requester's err pulse (no done pulse), then go to IDLE.
  - cmd_done_i in the same cycle the count is reached takes priority.
  - The counter clears on WAIT entry.
- Undefined: no counter; WAIT states wait indefinitely; cmd_timeout_o tied 0.

Test Plan:
- SW pulse, index 17, arg 0x0000_0200, type 10:
  - inhibit=1 next cycle;
  - cmd_start_o 1 cycle on the next sd_clk_en_p_i with index 17, arg 0x200;
  - cmd_done_i → sw_cmd_complete_o 1 cycle, inhibit=0.
- auto_cmd12_req_i and sw_cmd_valid_i in the same cycle:
  - cmd_start_o with index 12, arg 0, type 11;
  - sw_cmd_dropped_o 1 cycle;
  - after done: auto_cmd12_done_o, inhibit=0.
- auto_cmd12_req_i during WAIT_SW:
  - sw completes first;
  - CMD12 start follows within 2 cycles plus the enable wait;
  - auto_cmd12_active_o high throughout.
- cmd_done_i with cmd_err_i=1 during WAIT_AUTO → auto_cmd12_err_o and auto_cmd12_done_o, both 1 cycle.
- soft_rst_i during WAIT_SW → IDLE next cycle; no completion pulse; inhibit=0.
- With SDHCI_CMD_TIMEOUT_EN, TimeoutCycles=4, no cmd_done_i → cmd_timeout_o and sw_cmd_err_o on the 4th sd_clk_en_p_i, then inhibit=0.

Source files
------------

// File: rtl/sd_cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// sd_cmd_arbiter_if
//   Handshake between the command arbiter and the CMD-line serializer.
//
//   master (arbiter side):
//     cmd_start_o     out  one-cycle start pulse, aligned with the SD clock enable
//     cmd_index_o     out  6-bit command index
//     cmd_arg_o       out  32-bit command argument
//     cmd_rsp_type_o  out  response type (00 none, 01 R136, 10 R48, 11 R48b)
//     cmd_done_i      in   serializer finished, response received
//     cmd_err_i       in   CRC / end-bit / index error, qualified by cmd_done_i
//   slave (serializer side): same signals, opposite directions.
// -----------------------------------------------------------------------------
interface sd_cmd_arbiter_if;
    logic        cmd_start_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic [1:0]  cmd_rsp_type_o;
    logic        cmd_done_i;
    logic        cmd_err_i;

    modport master (
        output cmd_start_o,
        output cmd_index_o,
        output cmd_arg_o,
        output cmd_rsp_type_o,
        input  cmd_done_i,
        input  cmd_err_i
    );

    modport slave (
        input  cmd_start_o,
        input  cmd_index_o,
        input  cmd_arg_o,
        input  cmd_rsp_type_o,
        output cmd_done_i,
        output cmd_err_i
    );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sd_cmd_arbiter
//   Shares the single CMD-line serializer between software commands (Command
//   register writes) and Auto CMD12 requests from the DAT path. Each command is
//   sequenced from issue through response completion; Command Inhibit (CMD) and
//   per-requester completion / error pulses are reported.
//
//   Optional feature: define SDHCI_CMD_TIMEOUT_EN to enable a response timeout
//   of TimeoutCycles SD clock enables in the WAIT states. When undefined the
//   WAIT states wait indefinitely and cmd_timeout_o is tied 0.
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     sd_clk_en_p_i          SD clock rising-edge enable
//     soft_rst_i             synchronous CMD soft reset (keeps captured fields)
//     sw_cmd_valid_i         Command register write pulse
//     sw_cmd_index_i/arg_i/rsp_type_i  software command fields
//     auto_cmd12_req_i       Auto CMD12 request pulse from the DAT path
//     ser                    serializer handshake (sd_cmd_arbiter_if.master)
//     cmd_inhibit_o          CMD line busy
//     sw_cmd_complete_o / sw_cmd_err_o / sw_cmd_dropped_o   software pulses
//     auto_cmd12_active_o    Auto CMD12 pending or in flight
//     auto_cmd12_done_o / auto_cmd12_err_o                  Auto CMD12 pulses
//     cmd_timeout_o          response timeout pulse
// -----------------------------------------------------------------------------
module sd_cmd_arbiter #(
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned Cmd12Index    = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sd_clk_en_p_i,
    input  logic                    soft_rst_i,
    input  logic                    sw_cmd_valid_i,
    input  logic [5:0]              sw_cmd_index_i,
    input  logic [31:0]             sw_cmd_arg_i,
    input  logic [1:0]              sw_rsp_type_i,
    input  logic                    auto_cmd12_req_i,
    sd_cmd_arbiter_if.master        ser,
    output logic                    cmd_inhibit_o,
    output logic                    sw_cmd_complete_o,
    output logic                    sw_cmd_err_o,
    output logic                    sw_cmd_dropped_o,
    output logic                    auto_cmd12_active_o,
    output logic                    auto_cmd12_done_o,
    output logic                    auto_cmd12_err_o,
    output logic                    cmd_timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_SW,
        ST_ISSUE_AUTO,
        ST_WAIT_SW,
        ST_WAIT_AUTO
    } state_e;

    state_e      state_q, state_d;
    logic        sw_pend_q, sw_pend_d;
    logic        auto_pend_q, auto_pend_d;

    // Software command fields captured on an accepted Command register write.
    logic [5:0]  sw_index_q, sw_index_d;
    logic [31:0] sw_arg_q, sw_arg_d;
    logic [1:0]  sw_rsp_type_q, sw_rsp_type_d;

    // Fields presented to the serializer.
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [1:0]  cmd_rsp_type_q, cmd_rsp_type_d;

    logic        sw_complete_q, sw_complete_d;
    logic        sw_err_q, sw_err_d;
    logic        sw_dropped_q, sw_dropped_d;
    logic        auto_done_q, auto_done_d;
    logic        auto_err_q, auto_err_d;
    logic        timeout_q, timeout_d;

    logic        cmd_start;
    logic        sw_accept;

`ifdef SDHCI_CMD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_hit;
`endif

    // A write is only taken when the arbiter is fully idle; an Auto CMD12
    // request in the same cycle counts as already pending so that it wins.
    assign sw_accept = sw_cmd_valid_i && (state_q == ST_IDLE) &&
                       !sw_pend_q && !auto_pend_q && !auto_cmd12_req_i;

    always_comb begin
        state_d        = state_q;
        sw_pend_d      = sw_pend_q;
        auto_pend_d    = auto_pend_q;
        sw_index_d     = sw_index_q;
        sw_arg_d       = sw_arg_q;
        sw_rsp_type_d  = sw_rsp_type_q;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;
        cmd_rsp_type_d = cmd_rsp_type_q;
        sw_complete_d  = 1'b0;
        sw_err_d       = 1'b0;
        sw_dropped_d   = 1'b0;
        auto_done_d    = 1'b0;
        auto_err_d     = 1'b0;
        timeout_d      = 1'b0;
        cmd_start      = 1'b0;
`ifdef SDHCI_CMD_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        tmo_hit        = ((32'(tmo_cnt_q) + 32'd1) == TimeoutCycles);
`endif

        if (soft_rst_i) begin
            state_d        = ST_IDLE;
            sw_pend_d      = 1'b0;
            auto_pend_d    = 1'b0;
            cmd_index_d    = '0;
            cmd_arg_d      = '0;
            cmd_rsp_type_d = '0;
`ifdef SDHCI_CMD_TIMEOUT_EN
            tmo_cnt_d      = '0;
`endif
        end else begin
            if (sw_cmd_valid_i) begin
                if (sw_accept) begin
                    sw_pend_d     = 1'b1;
                    sw_index_d    = sw_cmd_index_i;
                    sw_arg_d      = sw_cmd_arg_i;
                    sw_rsp_type_d = sw_rsp_type_i;
                end else begin
                    sw_dropped_d  = 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (auto_pend_q) begin
                        cmd_index_d    = 6'(Cmd12Index);
                        cmd_arg_d      = '0;
                        cmd_rsp_type_d = 2'b11;
                        auto_pend_d    = 1'b0;
                        state_d        = ST_ISSUE_AUTO;
                    end else if (sw_pend_q) begin
                        cmd_index_d    = sw_index_q;
                        cmd_arg_d      = sw_arg_q;
                        cmd_rsp_type_d = sw_rsp_type_q;
                        sw_pend_d      = 1'b0;
                        state_d        = ST_ISSUE_SW;
                    end
                end
                ST_ISSUE_SW, ST_ISSUE_AUTO: begin
                    if (sd_clk_en_p_i) begin
                        cmd_start = 1'b1;
                        state_d   = (state_q == ST_ISSUE_SW) ? ST_WAIT_SW : ST_WAIT_AUTO;
`ifdef SDHCI_CMD_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
                ST_WAIT_SW, ST_WAIT_AUTO: begin
                    if (ser.cmd_done_i) begin
                        if (state_q == ST_WAIT_SW) begin
                            sw_complete_d = 1'b1;
                            sw_err_d      = ser.cmd_err_i;
                        end else begin
                            auto_done_d   = 1'b1;
                            auto_err_d    = ser.cmd_err_i;
                        end
                        state_d = ST_IDLE;
`ifdef SDHCI_CMD_TIMEOUT_EN
                    end else if (sd_clk_en_p_i) begin
                        if (tmo_hit) begin
                            // Timeout reports an error to the owner but no done.
                            timeout_d = 1'b1;
                            if (state_q == ST_WAIT_SW) begin
                                sw_err_d = 1'b1;
                            end else begin
                                auto_err_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Set after the IDLE dispatch so a request landing in the
            // dispatch cycle is queued rather than lost.
            if (auto_cmd12_req_i) begin
                auto_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            sw_pend_q      <= 1'b0;
            auto_pend_q    <= 1'b0;
            sw_index_q     <= '0;
            sw_arg_q       <= '0;
            sw_rsp_type_q  <= '0;
            cmd_index_q    <= '0;
            cmd_arg_q      <= '0;
            cmd_rsp_type_q <= '0;
            sw_complete_q  <= 1'b0;
            sw_err_q       <= 1'b0;
            sw_dropped_q   <= 1'b0;
            auto_done_q    <= 1'b0;
            auto_err_q     <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef SDHCI_CMD_TIMEOUT_EN
            tmo_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sw_pend_q      <= sw_pend_d;
            auto_pend_q    <= auto_pend_d;
            sw_index_q     <= sw_index_d;
            sw_arg_q       <= sw_arg_d;
            sw_rsp_type_q  <= sw_rsp_type_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
            cmd_rsp_type_q <= cmd_rsp_type_d;
            sw_complete_q  <= sw_complete_d;
            sw_err_q       <= sw_err_d;
            sw_dropped_q   <= sw_dropped_d;
            auto_done_q    <= auto_done_d;
            auto_err_q     <= auto_err_d;
            timeout_q      <= timeout_d;
`ifdef SDHCI_CMD_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
`endif
        end
    end

    // cmd_start is decoded in the enable cycle itself so the serializer sees
    // it aligned with sd_clk_en_p_i rather than one system clock late.
    assign ser.cmd_start_o    = cmd_start;
    assign ser.cmd_index_o    = cmd_index_q;
    assign ser.cmd_arg_o      = cmd_arg_q;
    assign ser.cmd_rsp_type_o = cmd_rsp_type_q;

    assign cmd_inhibit_o       = (state_q != ST_IDLE) || sw_pend_q || auto_pend_q;
    assign auto_cmd12_active_o = auto_pend_q || (state_q == ST_ISSUE_AUTO) ||
                                 (state_q == ST_WAIT_AUTO);

    assign sw_cmd_complete_o = sw_complete_q;
    assign sw_cmd_err_o      = sw_err_q;
    assign sw_cmd_dropped_o  = sw_dropped_q;
    assign auto_cmd12_done_o = auto_done_q;
    assign auto_cmd12_err_o  = auto_err_q;

`ifdef SDHCI_CMD_TIMEOUT_EN
    assign cmd_timeout_o = timeout_q;
`else
    assign cmd_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
module tb_sd_cmd_arbiter;
    logic        clk;
    logic        rst_n;
    logic        sd_clk_en_p;
    logic        soft_rst;
    logic        sw_cmd_valid;
    logic [5:0]  sw_cmd_index;
    logic [31:0] sw_cmd_arg;
    logic [1:0]  sw_rsp_type;
    logic        auto_cmd12_req;
    logic        cmd_inhibit;
    logic        sw_cmd_complete;
    logic        sw_cmd_err;
    logic        sw_cmd_dropped;
    logic        auto_cmd12_active;
    logic        auto_cmd12_done;
    logic        auto_cmd12_err;
    logic        cmd_timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sd_cmd_arbiter_if ser_if ();

    sd_cmd_arbiter #(
`ifdef SDHCI_CMD_TIMEOUT_EN
        .TimeoutCycles (4),
`else
        .TimeoutCycles (64),
`endif
        .Cmd12Index    (12)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .sd_clk_en_p_i       (sd_clk_en_p),
        .soft_rst_i          (soft_rst),
        .sw_cmd_valid_i      (sw_cmd_valid),
        .sw_cmd_index_i      (sw_cmd_index),
        .sw_cmd_arg_i        (sw_cmd_arg),
        .sw_rsp_type_i       (sw_rsp_type),
        .auto_cmd12_req_i    (auto_cmd12_req),
        .ser                 (ser_if.master),
        .cmd_inhibit_o       (cmd_inhibit),
        .sw_cmd_complete_o   (sw_cmd_complete),
        .sw_cmd_err_o        (sw_cmd_err),
        .sw_cmd_dropped_o    (sw_cmd_dropped),
        .auto_cmd12_active_o (auto_cmd12_active),
        .auto_cmd12_done_o   (auto_cmd12_done),
        .auto_cmd12_err_o    (auto_cmd12_err),
        .cmd_timeout_o       (cmd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_write(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
        sw_cmd_valid = 1'b1;
        sw_cmd_index = idx;
        sw_cmd_arg   = arg;
        sw_rsp_type  = typ;
        cyc();
        sw_cmd_valid = 1'b0;
        sw_cmd_index = 6'h3f;
        sw_cmd_arg   = 32'hffff_ffff;
        sw_rsp_type  = 2'b00;
    endtask

    // One SD clock enable; start must (or must not) coincide with it.
    task automatic en_pulse(input string tag, input logic exp_start);
        sd_clk_en_p = 1'b1;
        #1;
        check_val(tag, 32'(ser_if.cmd_start_o), 32'(exp_start));
        cyc();
        sd_clk_en_p = 1'b0;
    endtask

    task automatic done_pulse(input logic err);
        ser_if.cmd_done_i = 1'b1;
        ser_if.cmd_err_i  = err;
        cyc();
        ser_if.cmd_done_i = 1'b0;
        ser_if.cmd_err_i  = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        sd_clk_en_p       = 1'b0;
        soft_rst          = 1'b0;
        sw_cmd_valid      = 1'b0;
        sw_cmd_index      = '0;
        sw_cmd_arg        = '0;
        sw_rsp_type       = '0;
        auto_cmd12_req    = 1'b0;
        ser_if.cmd_done_i = 1'b0;
        ser_if.cmd_err_i  = 1'b0;

        // Reset state
        repeat (3) cyc();
        check_val("rst_inhibit",  32'(cmd_inhibit), 32'd0);
        check_val("rst_index",    32'(ser_if.cmd_index_o), 32'd0);
        check_val("rst_arg",      ser_if.cmd_arg_o, 32'd0);
        check_val("rst_type",     32'(ser_if.cmd_rsp_type_o), 32'd0);
        check_val("rst_start",    32'(ser_if.cmd_start_o), 32'd0);
        check_val("rst_active",   32'(auto_cmd12_active), 32'd0);
        check_val("rst_timeout",  32'(cmd_timeout), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Software command: index 17, arg 0x200, R48
        sw_write(6'd17, 32'h0000_0200, 2'b10);
        check_val("sw1_inhibit_pend", 32'(cmd_inhibit), 32'd1);
        check_val("sw1_idx_not_yet",  32'(ser_if.cmd_index_o), 32'd0);
        cyc();
        check_val("sw1_index", 32'(ser_if.cmd_index_o), 32'd17);
        check_val("sw1_arg",   ser_if.cmd_arg_o, 32'h0000_0200);
        check_val("sw1_type",  32'(ser_if.cmd_rsp_type_o), 32'd2);
        check_val("sw1_no_start_wo_en", 32'(ser_if.cmd_start_o), 32'd0);
        cyc();
        check_val("sw1_still_wait_en", 32'(ser_if.cmd_start_o), 32'd0);
        en_pulse("sw1_start", 1'b1);
        check_val("sw1_start_1cyc", 32'(ser_if.cmd_start_o), 32'd0);
        en_pulse("sw1_no_restart", 1'b0);
        check_val("sw1_inhibit_wait", 32'(cmd_inhibit), 32'd1);
        check_val("sw1_no_early_cpl", 32'(sw_cmd_complete), 32'd0);
        done_pulse(1'b0);
        check_val("sw1_complete", 32'(sw_cmd_complete), 32'd1);
        check_val("sw1_no_err",   32'(sw_cmd_err), 32'd0);
        check_val("sw1_inhibit_clr", 32'(cmd_inhibit), 32'd0);
        check_val("sw1_idx_hold", 32'(ser_if.cmd_index_o), 32'd17);
        cyc();
        check_val("sw1_complete_1cyc", 32'(sw_cmd_complete), 32'd0);

        // Stray done in IDLE is ignored
        done_pulse(1'b1);
        check_val("idle_done_cpl", 32'(sw_cmd_complete), 32'd0);
        check_val("idle_done_err", 32'(sw_cmd_err), 32'd0);
        check_val("idle_done_inh", 32'(cmd_inhibit), 32'd0);

        // Simultaneous Auto CMD12 and software write: CMD12 wins, sw dropped
        auto_cmd12_req = 1'b1;
        sw_write(6'd5, 32'h1234_5678, 2'b01);
        auto_cmd12_req = 1'b0;
        check_val("sim_dropped", 32'(sw_cmd_dropped), 32'd1);
        check_val("sim_active",  32'(auto_cmd12_active), 32'd1);
        check_val("sim_inhibit", 32'(cmd_inhibit), 32'd1);
        cyc();
        check_val("sim_dropped_1cyc", 32'(sw_cmd_dropped), 32'd0);
        check_val("sim_index", 32'(ser_if.cmd_index_o), 32'd12);
        check_val("sim_arg",   ser_if.cmd_arg_o, 32'd0);
        check_val("sim_type",  32'(ser_if.cmd_rsp_type_o), 32'd3);
        en_pulse("sim_start", 1'b1);
        done_pulse(1'b0);
        check_val("sim_auto_done", 32'(auto_cmd12_done), 32'd1);
        check_val("sim_auto_err",  32'(auto_cmd12_err), 32'd0);
        check_val("sim_sw_cpl",    32'(sw_cmd_complete), 32'd0);
        check_val("sim_inhibit_clr", 32'(cmd_inhibit), 32'd0);
        check_val("sim_active_clr",  32'(auto_cmd12_active), 32'd0);
        cyc();

        // Auto CMD12 arriving during WAIT_SW is queued behind the sw command
        sw_write(6'd8, 32'hdead_beef, 2'b01);
        cyc();
        en_pulse("q_sw_start", 1'b1);
        sw_write(6'd9, 32'h0, 2'b00);
        check_val("q_busy_dropped", 32'(sw_cmd_dropped), 32'd1);
        auto_cmd12_req = 1'b1;
        cyc();
        auto_cmd12_req = 1'b0;
        check_val("q_active_wait", 32'(auto_cmd12_active), 32'd1);
        check_val("q_index_sw",    32'(ser_if.cmd_index_o), 32'd8);
        done_pulse(1'b0);
        check_val("q_sw_complete", 32'(sw_cmd_complete), 32'd1);
        check_val("q_active_idle", 32'(auto_cmd12_active), 32'd1);
        check_val("q_inhibit",     32'(cmd_inhibit), 32'd1);
        cyc();
        check_val("q_auto_index",  32'(ser_if.cmd_index_o), 32'd12);
        check_val("q_auto_type",   32'(ser_if.cmd_rsp_type_o), 32'd3);
        check_val("q_active_issue", 32'(auto_cmd12_active), 32'd1);
        en_pulse("q_auto_start", 1'b1);
        check_val("q_active_waitauto", 32'(auto_cmd12_active), 32'd1);

        // Error on Auto CMD12 response
        done_pulse(1'b1);
        check_val("aerr_done", 32'(auto_cmd12_done), 32'd1);
        check_val("aerr_err",  32'(auto_cmd12_err), 32'd1);
        check_val("aerr_sw_err", 32'(sw_cmd_err), 32'd0);
        check_val("aerr_inhibit", 32'(cmd_inhibit), 32'd0);
        cyc();
        check_val("aerr_done_1cyc", 32'(auto_cmd12_done), 32'd0);
        check_val("aerr_err_1cyc",  32'(auto_cmd12_err), 32'd0);

        // Soft reset during WAIT_SW beats a same-cycle done
        sw_write(6'd13, 32'h0000_0055, 2'b11);
        cyc();
        en_pulse("srst_start", 1'b1);
        soft_rst = 1'b1;
        done_pulse(1'b0);
        soft_rst = 1'b0;
        check_val("srst_no_cpl",  32'(sw_cmd_complete), 32'd0);
        check_val("srst_inhibit", 32'(cmd_inhibit), 32'd0);
        cyc();
        check_val("srst_no_cpl_late", 32'(sw_cmd_complete), 32'd0);

        // Asynchronous reset mid-command
        sw_write(6'd2, 32'h0000_00aa, 2'b10);
        cyc();
        en_pulse("arst_start", 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_inhibit", 32'(cmd_inhibit), 32'd0);
        check_val("arst_index",   32'(ser_if.cmd_index_o), 32'd0);
        done_pulse(1'b0);
        check_val("arst_no_cpl",  32'(sw_cmd_complete), 32'd0);
        rst_n = 1'b1;
        cyc();

`ifdef SDHCI_CMD_TIMEOUT_EN
        // Timeout after 4 enables with no response
        sw_write(6'd17, 32'h0000_0200, 2'b10);
        cyc();
        en_pulse("tmo_start", 1'b1);
        for (int i = 0; i < 3; i++) begin
            en_pulse("tmo_no_restart", 1'b0);
            check_val("tmo_not_yet", 32'(cmd_timeout), 32'd0);
        end
        en_pulse("tmo_4th", 1'b0);
        check_val("tmo_pulse",   32'(cmd_timeout), 32'd1);
        check_val("tmo_sw_err",  32'(sw_cmd_err), 32'd1);
        check_val("tmo_no_cpl",  32'(sw_cmd_complete), 32'd0);
        check_val("tmo_inhibit", 32'(cmd_inhibit), 32'd0);
        cyc();
        check_val("tmo_pulse_1cyc", 32'(cmd_timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
